// File: rtl/gerador_codigo.sv
// Up/down sequencer over a fixed 10-entry code table with synchronous load,
// wrap or saturate at the ends, cascade carry, and a sticky invalid-load flag.
module gerador_codigo #(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] din,
    output logic       H,
    output logic       G,
    output logic       F,
    output logic       E,
    output logic       tc,
    output logic       err
);

    localparam logic [3:0] LAST_IDX = 4'd9;

    logic [3:0] idx_q, idx_d;
    logic [3:0] word_q, word_d;
    logic       err_q, err_d;
    logic       din_legal;
    logic [3:0] din_idx;
    logic       at_top, at_bottom;

    function automatic logic [3:0] code_of(input logic [3:0] i);
        logic [3:0] c;
        case (i)
            4'd0:    c = 4'b0000;
            4'd1:    c = 4'b0001;
            4'd2:    c = 4'b0011;
            4'd3:    c = 4'b0100;
            4'd4:    c = 4'b0101;
            4'd5:    c = 4'b0111;
            4'd6:    c = 4'b1001;
            4'd7:    c = 4'b1011;
            4'd8:    c = 4'b1100;
            4'd9:    c = 4'b1101;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // Inverse lookup: position of a loaded code, or flag it as not in the table.
    always_comb begin
        din_legal = 1'b1;
        din_idx   = 4'd0;
        case (din)
            4'b0000: din_idx = 4'd0;
            4'b0001: din_idx = 4'd1;
            4'b0011: din_idx = 4'd2;
            4'b0100: din_idx = 4'd3;
            4'b0101: din_idx = 4'd4;
            4'b0111: din_idx = 4'd5;
            4'b1001: din_idx = 4'd6;
            4'b1011: din_idx = 4'd7;
            4'b1100: din_idx = 4'd8;
            4'b1101: din_idx = 4'd9;
            default: din_legal = 1'b0;
        endcase
    end

    assign at_top    = (idx_q == LAST_IDX);
    assign at_bottom = (idx_q == 4'd0);

    always_comb begin
        idx_d = idx_q;
        err_d = err_q;
        if (load) begin
            if (din_legal) begin
                idx_d = din_idx;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (at_top) idx_d = WRAP ? 4'd0 : LAST_IDX;
                else        idx_d = idx_q + 4'd1;
            end else begin
                if (at_bottom) idx_d = WRAP ? LAST_IDX : 4'd0;
                else           idx_d = idx_q - 4'd1;
            end
        end
        // Word register is loaded from the next index so the code lands with the index.
        word_d = code_of(idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 4'd0;
            word_q <= 4'b0000;
            err_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            err_q  <= err_d;
        end
    end

    assign tc  = en & ~load & ((up & at_top) | (~up & at_bottom));
    assign H   = word_q[3];
    assign G   = word_q[2];
    assign F   = word_q[1];
    assign E   = word_q[0];
    assign err = err_q;

endmodule

// File: tb/tb_gerador_codigo.sv
// Scoreboard bench for gerador_codigo: one wrapping and one saturating instance
// share stimulus; each queued expectation names which instance it targets.
module tb_gerador_codigo;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load;
    logic [3:0] din;
    logic       sel;

    logic       h_w, g_w, f_w, e_w, tc_w, err_w;
    logic       h_s, g_s, f_s, e_s, tc_s, err_s;

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    typedef struct {
        logic       sel;
        logic [3:0] word;
        logic       err;
        logic       tc;
        int         step;
    } exp_t;

    exp_t exp_q[$];

    gerador_codigo #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .H(h_w), .G(g_w), .F(f_w), .E(e_w), .tc(tc_w), .err(err_w)
    );

    gerador_codigo #(.WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .H(h_s), .G(g_s), .F(f_s), .E(e_s), .tc(tc_s), .err(err_s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int id, input logic [3:0] actual,
                               input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s step%0d: got %b expected %b", name, id, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and queue what the targeted instance must show:
    // tc during this cycle, word/err after the next rising edge.
    task automatic applyStimulus(input logic s, input logic l, input logic [3:0] d,
                                 input logic e, input logic u, input logic tc_exp,
                                 input logic [3:0] word_exp, input logic err_exp);
        exp_t x;
        @(posedge clk);
        #2;
        sel  = s;
        load = l;
        din  = d;
        en   = e;
        up   = u;
        x.sel  = s;
        x.word = word_exp;
        x.err  = err_exp;
        x.tc   = tc_exp;
        x.step = step;
        exp_q.push_back(x);
        step++;
    endtask

    // Monitor: tc sampled mid-cycle, word/err sampled just after the edge.
    initial begin : monitor
        exp_t       x;
        logic       tc_now;
        logic [3:0] word_now;
        logic       err_now;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                x = exp_q[0];
                tc_now = x.sel ? tc_w : tc_s;
                @(posedge clk);
                #1;
                word_now = x.sel ? {h_w, g_w, f_w, e_w} : {h_s, g_s, f_s, e_s};
                err_now  = x.sel ? err_w : err_s;
                void'(exp_q.pop_front());
                checkOutput("tc",   x.step, {3'b0, tc_now},  {3'b0, x.tc});
                checkOutput("word", x.step, word_now,        x.word);
                checkOutput("err",  x.step, {3'b0, err_now}, {3'b0, x.err});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    localparam logic W = 1'b1;
    localparam logic S = 1'b0;

    initial begin : stimulus
        logic [3:0] seq [0:9];
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
                4'b0111, 4'b1001, 4'b1011, 4'b1100, 4'b1101};

        rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; din = 4'b0000; sel = W;
        #3;
        checkOutput("rst_word", -1, {h_w, g_w, f_w, e_w}, 4'b0000);
        checkOutput("rst_err",  -1, {3'b0, err_w}, 4'b0000);
        checkOutput("rst_tc",   -1, {3'b0, tc_w},  4'b0000);
        en = 1'b1; up = 1'b0;
        #1;
        checkOutput("rst_tc_down", -1, {3'b0, tc_w}, 4'b0001);
        en = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Forward run with wrap
        for (int k = 0; k < 11; k++)
            applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, (k == 9), seq[(k + 1) % 10], 1'b0);

        // Backward and forward saturation
        applyStimulus(S, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0);
        applyStimulus(S, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
        applyStimulus(S, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        applyStimulus(S, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(S, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(S, 1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 4'b1101, 1'b0);
        applyStimulus(S, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);

        // Illegal load and sticky err
        applyStimulus(W, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0);
        applyStimulus(W, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b1);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b1);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b1);
        applyStimulus(W, 1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 4'b1100, 1'b0);

        // Load wins over count at the top; backward wrap
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1101, 1'b0);
        applyStimulus(W, 1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b0);
        applyStimulus(W, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1101, 1'b0);

        // Direction flip, then hold
        applyStimulus(W, 1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
        applyStimulus(W, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);

        // Asynchronous reset mid-count with err set
        applyStimulus(W, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b0);
        applyStimulus(W, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b1);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b1);
        @(posedge clk);
        #3;
        checkOutput("pre_rst_word", -2, {h_w, g_w, f_w, e_w}, 4'b1001);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        checkOutput("async_rst_word", -2, {h_w, g_w, f_w, e_w}, 4'b0000);
        checkOutput("async_rst_err",  -2, {3'b0, err_w}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0);
        applyStimulus(W, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b0);
        applyStimulus(W, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gerador_codigo.md
GERADOR_CODIGO -- requirements
Module: gerador_codigo

Interface
REQ-001 The module SHALL have parameter WRAP, default 1, meaning 1 = wrap at sequence ends and 0 = saturate at sequence ends.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 The module SHALL have port en, input, 1 bit, the count enable.
REQ-005 The module SHALL have port up, input, 1 bit, the direction: 1 = forward, 0 = backward.
REQ-006 The module SHALL have port load, input, 1 bit, the synchronous load strobe.
REQ-007 The module SHALL have port din, input, 4 bits, the code to load, ordered {H,G,F,E}.
REQ-008 The module SHALL have ports H, G, F, E, outputs, 1 bit each, the registered code word fed directly to the downstream code converter (H = MSB).
REQ-009 The module SHALL have port tc, output, 1 bit, the terminal count / cascade carry.
REQ-010 The module SHALL have port err, output, 1 bit, the sticky invalid-load flag.

Function
REQ-011 The block SHALL hold a state index idx in 0..9 and drive {H,G,F,E} from a registered lookup of idx.
REQ-012 The lookup SHALL be idx 0..9 -> 0000, 0001, 0011, 0100, 0101, 0111, 1001, 1011, 1100, 1101.
REQ-013 The code word SHALL never take any other value: 0010, 0110, 1000, 1010, 1110, and 1111 are illegal on {H,G,F,E}.
REQ-014 Per-edge priority SHALL be, highest first: load, then en, then hold.
REQ-015 With load=1 and din equal to a legal code, idx SHALL become that code's position, the new word SHALL appear one cycle after the edge, and err SHALL clear.
REQ-016 With load=1 and din illegal, idx and the outputs SHALL remain unchanged and err SHALL be set.
REQ-017 err SHALL stay set until a legal load or reset; en activity SHALL NOT clear it.
REQ-018 With load=0, en=1, and up=1, idx SHALL advance by 1 per cycle; with up=0, idx SHALL decrease by 1 per cycle.
REQ-019 With WRAP=1, counting forward from idx 9 SHALL go to idx 0, and counting backward from idx 0 SHALL go to idx 9.
REQ-020 With WRAP=0, idx SHALL hold at 9 when counting forward and at 0 when counting backward.
REQ-021 With load=0 and en=0, all state SHALL hold.
REQ-022 tc SHALL be combinational: tc = en AND NOT load AND ((up AND idx==9) OR (NOT up AND idx==0)).
REQ-023 tc SHALL be asserted in the same cycle as the word that precedes the wrap or saturation.
REQ-024 A change of up while en=1 SHALL take effect on the next edge with no skipped or repeated code.
REQ-025 Simultaneous load=1 and en=1 SHALL perform the load only; tc SHALL be 0 in that cycle.
REQ-026 Latency from any control input to the code outputs SHALL be exactly one clock edge.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force idx=0, {H,G,F,E}=0000, and err=0.
REQ-028 During reset, tc SHALL follow REQ-022 with idx=0, so tc=1 only if en=1, up=0, and load=0.
REQ-029 Reset asserted mid-count or mid-load SHALL abort the operation.
REQ-030 After rst deasserts, the first rising edge SHALL act on the current inputs from idx 0.
REQ-031 Reset deassertion SHALL be synchronised externally; no internal synchroniser is required.

Verification
REQ-032 Forward sequence: rst pulse, then en=1, up=1, WRAP=1 for 11 cycles -> outputs 0000, 0001, 0011, 0100, 0101, 0111, 1001, 1011, 1100, 1101, 0000, with tc=1 only while 1101 is shown.
REQ-033 Backward and saturation: WRAP=0, load din=0011, then en=1, up=0 for 4 cycles -> outputs 0001, 0000, 0000, 0000, with tc=1 while 0000 is shown.
REQ-034 Illegal load: from word 0100, load din=1010 -> word stays 0100 and err=1; 3 count cycles leave err=1; then load din=1100 -> word 1100 and err=0.
REQ-035 Load priority: at word 1101 with en=1, up=1, load=1, din=0101 -> next word 0101, tc=0 in that cycle.
REQ-036 Asynchronous reset: mid-count at word 1001, assert rst between clock edges -> outputs 0000 and err=0 before the next edge, and counting restarts from 0000 after release.
REQ-037 Direction flip: at word 0111 with en=1, toggle up from 1 to 0 -> next words 0101 then 0100, with no 1001 in between.
